// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states and granted-port select.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mem_arbiter_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Granted-port select encoding
   localparam logic SEL_FETCH = 1'b0;
   localparam logic SEL_DATA  = 1'b1;

   // Word accesses only: any nonzero byte offset is rejected.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio2.sv
// 2-way priority picker: data wins unless fetch has been starved STARVE_LIMIT times.
// Latency: combinational.
// Backpressure: none; the caller only samples the grant when it is ready to arbitrate.
//   fetch_req/data_req : pending requests
//   starve_cnt         : consecutive data grants taken while fetch was pending
//   gnt_vld/gnt_sel    : some request is pending / which port wins (SEL_FETCH/SEL_DATA)
module arb_prio2
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic       fetch_req,
   input  logic       data_req,
   input  logic [3:0] starve_cnt,
   output logic       gnt_vld,
   output logic       gnt_sel
);

   logic force_fetch;

   assign force_fetch = fetch_req && (starve_cnt == 4'(STARVE_LIMIT));
   assign gnt_vld     = fetch_req | data_req;
   assign gnt_sel     = (data_req && !force_fetch) ? SEL_DATA : SEL_FETCH;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one byte-addressed single-port memory.
// Latency: ready WAIT_CYCLES+1 cycles after the sampling edge (1 cycle for misaligned requests).
// Backpressure: requesters hold req/addr/we/wdata until their ready pulse; the loser just waits.
//   clock, reset_n                                   : clock, async active-low reset
//   if_req/if_addr -> if_ready/if_rdata/if_err       : fetch port (read only)
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_ready/...    : data port (load/store)
//   mem_address/mem_data_in/mem_read_write, mem_data_out : memory port (combinational read)
//   busy                                             : FSM not idle
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ready,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_out,
   output logic        busy
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  starve_q, starve_d;
   logic        sel_q, sel_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;

   logic gnt_vld, gnt_sel;
   logic in_access, in_resp, last_access;

   arb_prio2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
      .fetch_req (if_req),
      .data_req  (dm_req),
      .starve_cnt(starve_q),
      .gnt_vld   (gnt_vld),
      .gnt_sel   (gnt_sel)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      sel_d      = sel_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               sel_d = gnt_sel;
               if (gnt_sel == SEL_DATA) begin
                  addr_d  = dm_addr;
                  we_d    = dm_we;
                  wdata_d = dm_wdata;
               end else begin
                  addr_d  = if_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
               // Only a data grant that overtakes a waiting fetch counts as starvation.
               starve_d = (gnt_sel == SEL_DATA && if_req) ? starve_q + 4'd1 : 4'd0;
               if (is_misaligned(addr_d)) begin
                  // Rejected without touching memory; answered straight from RESP.
                  err_d   = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  cnt_d   = CNT_INIT;
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) begin
                  if (sel_q == SEL_DATA) dm_rdata_d = mem_data_out;
                  else                   if_rdata_d = mem_data_out;
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         starve_q   <= 4'd0;
         sel_q      <= SEL_FETCH;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Memory outputs are decoded from state so an async reset drops them at once.
   assign in_access   = (state_q == ST_ACCESS);
   assign in_resp     = (state_q == ST_RESP);
   assign last_access = in_access && (cnt_q == 4'd0);

   assign mem_address    = in_access ? addr_q : '0;
   assign mem_data_in    = (in_access && we_q) ? wdata_q : '0;
   // Single write strobe on the last access cycle: one write edge per store.
   assign mem_read_write = last_access && we_q;

   assign if_ready = in_resp && (sel_q == SEL_FETCH);
   assign dm_ready = in_resp && (sel_q == SEL_DATA);
   assign if_err   = if_ready && err_q;
   assign dm_err   = dm_ready && err_q;
   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=1.
// Each instance has its own behavioural memory; expectations come from a shadow memory
// and a queue of expected responses pushed when each request is driven.
module tb_mem_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n        [2];
   logic        if_req         [2];
   logic [31:0] if_addr        [2];
   logic        if_ready       [2];
   logic [31:0] if_rdata       [2];
   logic        if_err         [2];
   logic        dm_req         [2];
   logic        dm_we          [2];
   logic [31:0] dm_addr        [2];
   logic [31:0] dm_wdata       [2];
   logic        dm_ready       [2];
   logic [31:0] dm_rdata       [2];
   logic        dm_err         [2];
   logic [31:0] mem_address    [2];
   logic [31:0] mem_data_in    [2];
   logic        mem_read_write [2];
   logic [31:0] mem_data_out   [2];
   logic        busy           [2];

   logic [31:0] mem    [2][64];
   logic [31:0] shadow [2][64];
   logic [31:0] exp_if [2];
   logic [31:0] exp_dm [2];
   int          wr_cnt [2] = '{0, 0};

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sbq[$];

   mem_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(4)) u_dut0 (
      .clock(clock), .reset_n(reset_n[0]),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]),
      .if_rdata(if_rdata[0]), .if_err(if_err[0]),
      .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
      .dm_ready(dm_ready[0]), .dm_rdata(dm_rdata[0]), .dm_err(dm_err[0]),
      .mem_address(mem_address[0]), .mem_data_in(mem_data_in[0]),
      .mem_read_write(mem_read_write[0]), .mem_data_out(mem_data_out[0]),
      .busy(busy[0])
   );

   mem_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut1 (
      .clock(clock), .reset_n(reset_n[1]),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]),
      .if_rdata(if_rdata[1]), .if_err(if_err[1]),
      .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
      .dm_ready(dm_ready[1]), .dm_rdata(dm_rdata[1]), .dm_err(dm_err[1]),
      .mem_address(mem_address[1]), .mem_data_in(mem_data_in[1]),
      .mem_read_write(mem_read_write[1]), .mem_data_out(mem_data_out[1]),
      .busy(busy[1])
   );

   // Behavioural memories: combinational read, write on the clock edge while strobed.
   assign mem_data_out[0] = mem[0][mem_address[0][7:2]];
   assign mem_data_out[1] = mem[1][mem_address[1][7:2]];

   always @(posedge clock) begin
      for (int d = 0; d < 2; d++) begin
         if (mem_read_write[d]) begin
            mem[d][mem_address[d][7:2]] <= mem_data_in[d];
            wr_cnt[d] <= wr_cnt[d] + 1;
         end
      end
   end

   function automatic int wcyc(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Issue one request (port: 0=fetch, 1=data) from an idle DUT and check its response.
   task automatic do_req(input int d, input bit port, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
      exp_t        e;
      bit          mis;
      bit          got;
      int          n;
      int          wr0;
      int          viol;
      logic [31:0] obs_rdata;
      logic        obs_err;
      mis  = (addr[1:0] != 2'b00);
      got  = 1'b0;
      n    = 0;
      viol = 0;
      e.err = mis;
      e.lat = mis ? 1 : wcyc(d) + 1;
      if (port) e.rdata = (mis || we) ? exp_dm[d] : shadow[d][addr[7:2]];
      else      e.rdata = mis ? exp_if[d] : shadow[d][addr[7:2]];
      if (!mis) begin
         if (we)        shadow[d][addr[7:2]] = wdata;
         else if (port) exp_dm[d] = e.rdata;
         else           exp_if[d] = e.rdata;
      end
      sbq.push_back(e);
      wr0 = wr_cnt[d];
      if (port) begin
         dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wdata;
      end else begin
         if_req[d] = 1'b1; if_addr[d] = addr;
      end
      while (!got && n < 20) begin
         @(negedge clock);
         n++;
         if (n == 1 && !mis) begin
            chk($sformatf("d%0d_%s_mem_address", d, tag), mem_address[d], addr);
            chk($sformatf("d%0d_%s_mem_data_in", d, tag), mem_data_in[d], we ? wdata : 32'h0);
         end
         got = port ? dm_ready[d] : if_ready[d];
         if (!got && (if_err[d] || dm_err[d])) viol++;
         if (got && (port ? if_ready[d] : dm_ready[d])) viol++;
      end
      obs_rdata = port ? dm_rdata[d] : if_rdata[d];
      obs_err   = port ? dm_err[d]   : if_err[d];
      chk($sformatf("d%0d_%s_resp_mem_idle", d, tag),
          {mem_read_write[d], mem_address[d][30:0]}, 32'h0);
      if (port) begin dm_req[d] = 1'b0; dm_we[d] = 1'b0; end
      else      if_req[d] = 1'b0;
      e = sbq.pop_front();
      chk($sformatf("d%0d_%s_latency", d, tag), got ? 32'(n) : 32'd99, 32'(e.lat));
      chk($sformatf("d%0d_%s_rdata", d, tag), obs_rdata, e.rdata);
      chk($sformatf("d%0d_%s_err", d, tag), {31'b0, obs_err}, {31'b0, e.err});
      chk($sformatf("d%0d_%s_protocol_violations", d, tag), 32'(viol), 32'd0);
      @(negedge clock);
      chk($sformatf("d%0d_%s_write_count", d, tag), 32'(wr_cnt[d] - wr0),
          (we && !mis) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d_%s_idle_after", d, tag), {31'b0, busy[d]}, 32'h0);
   endtask

   // Both ports requesting continuously; grants must come out D,D,D,D,F twice.
   task automatic contend(input int d);
      bit exp_q[$];
      bit ex;
      int grants;
      int cyc;
      grants = 0;
      cyc    = 0;
      for (int r = 0; r < 2; r++) begin
         repeat (4) exp_q.push_back(1'b1);
         exp_q.push_back(1'b0);
      end
      exp_if[d] = shadow[d][4];
      exp_dm[d] = shadow[d][8];
      if_req[d] = 1'b1; if_addr[d] = 32'h10;
      dm_req[d] = 1'b1; dm_we[d] = 1'b0; dm_addr[d] = 32'h20;
      while (grants < 10 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (if_ready[d] || dm_ready[d]) begin
            ex = exp_q.pop_front();
            chk($sformatf("d%0d_contend_grant%0d", d, grants),
                {30'b0, if_ready[d], dm_ready[d]}, ex ? 32'h1 : 32'h2);
            grants++;
         end
      end
      if_req[d] = 1'b0;
      dm_req[d] = 1'b0;
      chk($sformatf("d%0d_contend_grant_total", d), 32'(grants), 32'd10);
      chk($sformatf("d%0d_contend_if_rdata", d), if_rdata[d], exp_if[d]);
      chk($sformatf("d%0d_contend_dm_rdata", d), dm_rdata[d], exp_dm[d]);
      repeat (2) @(negedge clock);
   endtask

   // Reset asserted in the first ACCESS cycle of a store, then a clean fetch.
   task automatic reset_mid_store(input int d);
      int wr0;
      wr0 = wr_cnt[d];
      dm_req[d] = 1'b1; dm_we[d] = 1'b1; dm_addr[d] = 32'h30; dm_wdata[d] = 32'hCAFE_F00D;
      @(posedge clock);
      #1;
      chk($sformatf("d%0d_rst_busy_before", d), {31'b0, busy[d]}, 32'h1);
      reset_n[d] = 1'b0;
      #1;
      chk($sformatf("d%0d_rst_mem_rw", d), {31'b0, mem_read_write[d]}, 32'h0);
      chk($sformatf("d%0d_rst_busy", d), {31'b0, busy[d]}, 32'h0);
      chk($sformatf("d%0d_rst_mem_address", d), mem_address[d], 32'h0);
      chk($sformatf("d%0d_rst_dm_rdata", d), dm_rdata[d], 32'h0);
      chk($sformatf("d%0d_rst_if_rdata", d), if_rdata[d], 32'h0);
      exp_if[d] = 32'h0;
      exp_dm[d] = 32'h0;
      dm_req[d] = 1'b0; dm_we[d] = 1'b0;
      repeat (2) @(negedge clock);
      reset_n[d] = 1'b1;
      chk($sformatf("d%0d_rst_mem_unchanged", d), mem[d][12], shadow[d][12]);
      chk($sformatf("d%0d_rst_no_write", d), 32'(wr_cnt[d] - wr0), 32'd0);
      do_req(d, 1'b0, 1'b0, 32'h10, 32'h0, "post_rst_fetch");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset_n[d] = 1'b0;
         if_req[d]  = 1'b0; if_addr[d] = '0;
         dm_req[d]  = 1'b0; dm_we[d] = 1'b0; dm_addr[d] = '0; dm_wdata[d] = '0;
         exp_if[d]  = '0;   exp_dm[d] = '0;
         for (int i = 0; i < 64; i++) begin
            mem[d][i]    = 32'hA5A5_0000 | 32'(i);
            shadow[d][i] = 32'hA5A5_0000 | 32'(i);
         end
         mem[d][4]     = 32'hDEAD_BEEF;
         shadow[d][4]  = 32'hDEAD_BEEF;
         mem[d][12]    = 32'h0BAD_F00D;
         shadow[d][12] = 32'h0BAD_F00D;
      end
      repeat (3) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_reset_busy", d), {31'b0, busy[d]}, 32'h0);
         chk($sformatf("d%0d_reset_ready_err", d),
             {28'b0, if_ready[d], dm_ready[d], if_err[d], dm_err[d]}, 32'h0);
         chk($sformatf("d%0d_reset_if_rdata", d), if_rdata[d], 32'h0);
         chk($sformatf("d%0d_reset_dm_rdata", d), dm_rdata[d], 32'h0);
         chk($sformatf("d%0d_reset_mem_address", d), mem_address[d], 32'h0);
         chk($sformatf("d%0d_reset_mem_data_rw", d),
             mem_data_in[d] | {31'b0, mem_read_write[d]}, 32'h0);
         reset_n[d] = 1'b1;
      end
      @(negedge clock);

      for (int d = 0; d < 2; d++) begin
         do_req(d, 1'b0, 1'b0, 32'h10, 32'h0,         "fetch");
         do_req(d, 1'b1, 1'b1, 32'h20, 32'h1234_5678, "store");
         do_req(d, 1'b1, 1'b0, 32'h20, 32'h0,         "load");
         do_req(d, 1'b1, 1'b0, 32'h22, 32'h0,         "mis_load");
         do_req(d, 1'b1, 1'b1, 32'h26, 32'h5555_AAAA, "mis_store");
         do_req(d, 1'b0, 1'b0, 32'h11, 32'h0,         "mis_fetch");
         do_req(d, 1'b0, 1'b0, 32'h14, 32'h0,         "fetch2");
         contend(d);
         reset_mid_store(d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
